// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared 640x480@60 geometry, counter/address widths and RGB444 colour
//   constants. The graphics processor that fills VRAM uses the same visible
//   width/height, so both sides agree on the y*width+x address layout.
//   The *_DEF constants are the defaults for the per-module parameters.
//   bar_colour() maps a colour-bar index (0..7) to its RGB444 value.
package vga_timing_pkg;

  localparam int H_VIS_DEF        = 640;
  localparam int H_FP_DEF         = 16;
  localparam int H_SYNC_DEF       = 96;
  localparam int H_BP_DEF         = 48;
  localparam int H_TOTAL_DEF      = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int H_SYNC_START_DEF = H_VIS_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;

  localparam int V_VIS_DEF        = 480;
  localparam int V_FP_DEF         = 10;
  localparam int V_SYNC_DEF       = 2;
  localparam int V_BP_DEF         = 33;
  localparam int V_TOTAL_DEF      = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int V_SYNC_START_DEF = V_VIS_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  localparam int CNT_W  = 10;
  localparam int ADDR_W = 19;
  localparam int RGB_W  = 12;

  typedef logic [RGB_W-1:0] rgb444_t;

  localparam rgb444_t COL_WHITE   = 12'hFFF;
  localparam rgb444_t COL_YELLOW  = 12'hFF0;
  localparam rgb444_t COL_CYAN    = 12'h0FF;
  localparam rgb444_t COL_GREEN   = 12'h0F0;
  localparam rgb444_t COL_MAGENTA = 12'hF0F;
  localparam rgb444_t COL_RED     = 12'hF00;
  localparam rgb444_t COL_BLUE    = 12'h00F;
  localparam rgb444_t COL_BLACK   = 12'h000;

  // Colour of bar idx, left to right across the visible line.
  function automatic rgb444_t bar_colour(input logic [2:0] idx);
    rgb444_t col;
    case (idx)
      3'd0:    col = COL_WHITE;
      3'd1:    col = COL_YELLOW;
      3'd2:    col = COL_CYAN;
      3'd3:    col = COL_GREEN;
      3'd4:    col = COL_MAGENTA;
      3'd5:    col = COL_RED;
      3'd6:    col = COL_BLUE;
      default: col = COL_BLACK;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Pixel-rate divider plus horizontal/vertical raster counters. Produces the
//   stage-0 view of the raster: counters, visible flag and active-low syncs,
//   all combinational from the counter registers.
// Ports
//   clk, rst_n      system clock, synchronous active-low reset
//   o_pix_tick      1 on the last system clock of each pixel slot
//   o_h_cnt/o_v_cnt current column / line
//   o_vis           current position is inside the visible area
//   o_hs_n/o_vs_n   horizontal / vertical sync, active-low
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = H_VIS_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_VIS   = V_VIS_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             o_pix_tick,
  output logic [CNT_W-1:0] o_h_cnt,
  output logic [CNT_W-1:0] o_v_cnt,
  output logic             o_vis,
  output logic             o_hs_n,
  output logic             o_vs_n
);

  localparam logic [3:0]       DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [CNT_W-1:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  logic [3:0]       r_div_cnt;
  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;

  assign o_pix_tick = (r_div_cnt == DIV_LAST);
  assign o_h_cnt    = r_h_cnt;
  assign o_v_cnt    = r_v_cnt;
  assign o_vis      = (r_h_cnt < H_VIS_C) && (r_v_cnt < V_VIS_C);
  assign o_hs_n     = !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
  assign o_vs_n     = !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));

  // Clock divider and raster counters; counters advance once per pixel slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt <= 4'd0;
      r_h_cnt   <= 10'd0;
      r_v_cnt   <= 10'd0;
    end else begin
      if (o_pix_tick) begin
        r_div_cnt <= 4'd0;
        if (r_h_cnt == H_LAST) begin
          r_h_cnt <= 10'd0;
          if (r_v_cnt == V_LAST) begin
            r_v_cnt <= 10'd0;
          end else begin
            r_v_cnt <= r_v_cnt + 10'd1;
          end
        end else begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end
      end else begin
        r_div_cnt <= r_div_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout
//   Display-side VRAM reader. Stage 1 registers the VRAM address (y*H_VIS+x)
//   together with the visible flag and syncs; stage 2 registers RGB and syncs
//   to the pins, so pixels and syncs leave with the same 2-pixel latency.
//   VRAM data must return within CLK_DIV-1 clocks of the address.
// Ports
//   clk, rst_n     system clock, synchronous active-low reset
//   vram_addr      registered VRAM read address
//   vram_data      VRAM read data {R,G,B}, valid 1 clk after vram_addr
//   vga_r/g/b      4-bit colour outputs, zero during blanking
//   vga_hs/vga_vs  active-low syncs
//   frame_start    one-clk pulse after the address of pixel (0,0) is issued
//   test_mode      colour-bar select (only with SCANOUT_TEST_PATTERN_EN)
// Build option
//   SCANOUT_TEST_PATTERN_EN  adds test_mode and an 8-bar colour pattern
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = H_VIS_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_VIS   = V_VIS_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [RGB_W-1:0]  vram_data,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              frame_start
`ifdef SCANOUT_TEST_PATTERN_EN
  ,
  input  logic              test_mode
`endif
);

  // Constant multiplier; for 640 this reduces to (y<<9)+(y<<7).
  localparam logic [ADDR_W-1:0] H_STRIDE = 19'(H_VIS);

  logic             w_pix_tick;
  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_v_cnt;
  logic             w_vis;
  logic             w_hs_n;
  logic             w_vs_n;
  logic [ADDR_W-1:0] w_addr;
  rgb444_t          w_rgb_next;

  logic [ADDR_W-1:0] r_vram_addr;
  logic             r_vis_d;
  logic             r_hs_d;
  logic             r_vs_d;
  logic             r_frame_start;
  rgb444_t          r_rgb;
  logic             r_hs;
  logic             r_vs;

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV),
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .o_pix_tick(w_pix_tick),
    .o_h_cnt   (w_h_cnt),
    .o_v_cnt   (w_v_cnt),
    .o_vis     (w_vis),
    .o_hs_n    (w_hs_n),
    .o_vs_n    (w_vs_n)
  );

  // Max product stays below 2^19 for the supported geometry, so no overflow.
  assign w_addr = {9'd0, w_v_cnt} * H_STRIDE + {9'd0, w_h_cnt};

`ifdef SCANOUT_TEST_PATTERN_EN
  localparam int BAR_W = H_VIS / 8;

  logic [2:0] w_bar_idx;
  logic [2:0] r_bar_idx;

  // Bar index = number of bar boundaries at or left of the current column.
  always_comb begin
    w_bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      w_bar_idx = w_bar_idx + {2'b00, (32'(w_h_cnt) >= i * BAR_W)};
    end
  end

  // Bar index travels with the stage-1 address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bar_idx <= 3'd0;
    end else if (w_pix_tick) begin
      r_bar_idx <= w_bar_idx;
    end else begin
      r_bar_idx <= r_bar_idx;
    end
  end
`endif

  // Stage-2 colour: VRAM data (or bar colour) when visible, black otherwise.
  always_comb begin
    w_rgb_next = COL_BLACK;
    if (r_vis_d) begin
`ifdef SCANOUT_TEST_PATTERN_EN
      if (test_mode) begin
        w_rgb_next = bar_colour(r_bar_idx);
      end else begin
        w_rgb_next = vram_data;
      end
`else
      w_rgb_next = vram_data;
`endif
    end else begin
      w_rgb_next = COL_BLACK;
    end
  end

  // Stage 1: address plus delayed visible flag and syncs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vram_addr <= 19'd0;
      r_vis_d     <= 1'b0;
      r_hs_d      <= 1'b1;
      r_vs_d      <= 1'b1;
    end else if (w_pix_tick) begin
      r_vram_addr <= w_vis ? w_addr : 19'd0;
      r_vis_d     <= w_vis;
      r_hs_d      <= w_hs_n;
      r_vs_d      <= w_vs_n;
    end else begin
      r_vram_addr <= r_vram_addr;
      r_vis_d     <= r_vis_d;
      r_hs_d      <= r_hs_d;
      r_vs_d      <= r_vs_d;
    end
  end

  // Stage 2: pin registers for colour and syncs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rgb <= COL_BLACK;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
    end else if (w_pix_tick) begin
      r_rgb <= w_rgb_next;
      r_hs  <= r_hs_d;
      r_vs  <= r_vs_d;
    end else begin
      r_rgb <= r_rgb;
      r_hs  <= r_hs;
      r_vs  <= r_vs;
    end
  end

  // Pulse on the clock after (0,0) is loaded; cleared next clk since CLK_DIV >= 2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_pix_tick && (w_h_cnt == 10'd0) && (w_v_cnt == 10'd0);
    end
  end

  assign vram_addr   = r_vram_addr;
  assign vga_r       = r_rgb[11:8];
  assign vga_g       = r_rgb[7:4];
  assign vga_b       = r_rgb[3:0];
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout
//   Two instances: dut_f with the full 640x480 geometry (CLK_DIV=4) for line
//   timing, data path and blanking; dut_s with a tiny 16x6 raster (CLK_DIV=2)
//   so frame-level events (last pixel, VS, frame_start, mid-frame reset) fit
//   in a short run. VRAM models return addr[11:0] one clock after the address.
`timescale 1ns/1ps
module tb_vga_scanout;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;

  logic        rst_n_f, rst_n_s;
  logic        force_fff;
  logic [18:0] addr_f, addr_s;
  logic [11:0] data_f, data_s;
  logic [3:0]  r_f, g_f, b_f, r_s, g_s, b_s;
  logic        hs_f, vs_f, fs_f, hs_s, vs_s, fs_s;
  logic        test_mode_f, test_mode_s;
  logic [11:0] rgb_f, rgb_s;

  int          hs_fall_q[$];
  int          hs_rise_q[$];
  logic        hs_prev = 1'b1;

  assign rgb_f = {r_f, g_f, b_f};
  assign rgb_s = {r_s, g_s, b_s};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) data_f <= force_fff ? 12'hFFF : addr_f[11:0];
  always @(posedge clk) data_s <= addr_s[11:0];

  always @(negedge clk) begin
    if (rst_n_f) begin
      if (hs_prev && !hs_f) hs_fall_q.push_back(cyc);
      if (!hs_prev && hs_f) hs_rise_q.push_back(cyc);
    end
    hs_prev <= hs_f;
  end

  vga_scanout dut_f (
    .clk(clk), .rst_n(rst_n_f), .vram_addr(addr_f), .vram_data(data_f),
    .vga_r(r_f), .vga_g(g_f), .vga_b(b_f), .vga_hs(hs_f), .vga_vs(vs_f),
    .frame_start(fs_f)
`ifdef SCANOUT_TEST_PATTERN_EN
    , .test_mode(test_mode_f)
`endif
  );

  vga_scanout #(
    .CLK_DIV(2),
    .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_VIS(6),  .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n_s), .vram_addr(addr_s), .vram_data(data_s),
    .vga_r(r_s), .vga_g(g_s), .vga_b(b_s), .vga_hs(hs_s), .vga_vs(vs_s),
    .frame_start(fs_s)
`ifdef SCANOUT_TEST_PATTERN_EN
    , .test_mode(test_mode_s)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_fs(input bit sel, input int limit, input string tag, output int at);
    bit found;
    found = 1'b0;
    at = cyc;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if ((sel ? fs_s : fs_f) == 1'b1) begin
        found = 1'b1;
        at = cyc;
      end
    end
    check_val(tag, {31'd0, found}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int t_f, t_s, t_r, rel;
    rst_n_f = 1'b0;
    rst_n_s = 1'b0;
    force_fff = 1'b0;
    test_mode_f = 1'b0;
    test_mode_s = 1'b0;
    repeat (5) @(negedge clk);

    // Reset state, both instances
    check_val("rst_addr_f", 32'(addr_f), 32'd0);
    check_val("rst_rgb_f",  32'(rgb_f),  32'h000);
    check_val("rst_hs_f",   32'(hs_f),   32'd1);
    check_val("rst_vs_f",   32'(vs_f),   32'd1);
    check_val("rst_fs_f",   32'(fs_f),   32'd0);
    check_val("rst_addr_s", 32'(addr_s), 32'd0);
    check_val("rst_hs_s",   32'(hs_s),   32'd1);
    check_val("rst_vs_s",   32'(vs_s),   32'd1);

    // ---- Full geometry: pixel g = v*800+h; addr at fs+4g+1, pins at fs+4g+5
    rst_n_f = 1'b1;
    wait_fs(1'b0, 20, "fs_f_first", t_f);
    force_fff = 1'b1;
    wait_until(t_f + 2561);
    check_val("addr_h640",    32'(addr_f), 32'd0);
    check_val("rgb_h639_vis", 32'(rgb_f),  32'hFFF);
    wait_until(t_f + 2565);
    check_val("rgb_h640_blank", 32'(rgb_f), 32'h000);
    wait_until(t_f + 2805);
    check_val("rgb_h700_blank", 32'(rgb_f), 32'h000);
    wait_until(t_f + 3197);
    check_val("addr_h799", 32'(addr_f), 32'd0);
    wait_until(t_f + 3201);
    check_val("rgb_h799_blank", 32'(rgb_f), 32'h000);
    force_fff = 1'b0;

    wait_until(t_f + 6421);
    check_val("addr_5_2", 32'(addr_f), 32'd1285);
    wait_until(t_f + 6425);
    check_val("rgb_5_2", 32'(rgb_f), 32'h505);
    check_val("hs_5_2",  32'(hs_f),  32'd1);
    check_val("vs_5_2",  32'(vs_f),  32'd1);

    check_val("hs_edges_seen", 32'(hs_fall_q.size() >= 2 && hs_rise_q.size() >= 1), 32'd1);
    if (hs_fall_q.size() >= 2 && hs_rise_q.size() >= 1) begin
      check_val("hs_first_fall", 32'(hs_fall_q[0] - t_f),          32'd2628);
      check_val("hs_period",     32'(hs_fall_q[1] - hs_fall_q[0]), 32'd3200);
      check_val("hs_low",        32'(hs_rise_q[0] - hs_fall_q[0]), 32'd384);
    end

`ifdef SCANOUT_TEST_PATTERN_EN
    test_mode_f = 1'b1;
    wait_until(t_f + 9601);
    check_val("tp_addr_0_3", 32'(addr_f), 32'd1920);
    wait_until(t_f + 9605);
    check_val("tp_x0",   32'(rgb_f), 32'hFFF);
    wait_until(t_f + 9925);
    check_val("tp_x80",  32'(rgb_f), 32'hFF0);
    wait_until(t_f + 10245);
    check_val("tp_x160", 32'(rgb_f), 32'h0FF);
    wait_until(t_f + 12161);
    check_val("tp_x639", 32'(rgb_f), 32'h000);
    test_mode_f = 1'b0;
`endif

    // ---- Small geometry: 24x10 raster, g = v*24+h; addr at fs+2g, pins at fs+2g+2
    rst_n_s = 1'b1;
    wait_fs(1'b1, 20, "fs_s_first", t_s);
    wait_until(t_s + 36);
    check_val("s_hs_h17", 32'(hs_s), 32'd1);
    wait_until(t_s + 38);
    check_val("s_hs_h18", 32'(hs_s), 32'd0);
    wait_until(t_s + 44);
    check_val("s_hs_h21", 32'(hs_s), 32'd0);
    wait_until(t_s + 46);
    check_val("s_hs_h22", 32'(hs_s), 32'd1);
    wait_until(t_s + 270);
    check_val("s_addr_last_vis", 32'(addr_s), 32'd95);
    wait_until(t_s + 272);
    check_val("s_addr_h16",     32'(addr_s), 32'd0);
    check_val("s_rgb_last_vis", 32'(rgb_s),  32'h05F);
    wait_until(t_s + 336);
    check_val("s_vs_l6", 32'(vs_s), 32'd1);
    wait_until(t_s + 338);
    check_val("s_vs_l7", 32'(vs_s), 32'd0);
    wait_until(t_s + 432);
    check_val("s_vs_l8", 32'(vs_s), 32'd0);
    wait_until(t_s + 434);
    check_val("s_vs_l9", 32'(vs_s), 32'd1);
    wait_until(t_s + 479);
    check_val("s_fs_before", 32'(fs_s), 32'd0);
    wait_until(t_s + 480);
    check_val("s_fs_pulse",  32'(fs_s),   32'd1);
    check_val("s_addr_0_0",  32'(addr_s), 32'd0);
    wait_until(t_s + 481);
    check_val("s_fs_after",  32'(fs_s), 32'd0);
    wait_until(t_s + 482);
    check_val("s_addr_1_0",  32'(addr_s), 32'd1);

    // Mid-frame reset for one clock at pixel (10,3) of the second frame
    wait_until(t_s + 646);
    check_val("s_rgb_10_3", 32'(rgb_s), 32'h03A);
    rst_n_s = 1'b0;
    @(negedge clk);
    check_val("s_mrst_hs",   32'(hs_s),   32'd1);
    check_val("s_mrst_vs",   32'(vs_s),   32'd1);
    check_val("s_mrst_rgb",  32'(rgb_s),  32'h000);
    check_val("s_mrst_addr", 32'(addr_s), 32'd0);
    rst_n_s = 1'b1;
    rel = cyc;
    wait_fs(1'b1, 20, "s_fs_after_rst", t_r);
    check_val("s_fs_rst_lat",   32'(t_r - rel), 32'd2);
    check_val("s_addr_rst_0",   32'(addr_s),    32'd0);
    check_val("s_rgb_rst_zero", 32'(rgb_s),     32'h000);
    wait_until(t_r + 2);
    check_val("s_addr_rst_1", 32'(addr_s), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
